// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer.
// ALU_OP_ADD is also referenced by the shared ALU decode.
package alu_mul_seq_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned MUL_ITERS = 16;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

  localparam logic [OP_W-1:0]  ALU_OP_ADD = 4'b0000;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MUL_ITERS - 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Partial-product addend for the current multiplier LSB.
  function automatic logic [DATA_W-1:0] addend_sel(input logic bit0,
                                                   input logic [DATA_W-1:0] mcand);
    return bit0 ? mcand : '0;
  endfunction

endpackage

// File: rtl/alu_mul_seq_dp.sv
// Multiply datapath: hi/lo/mcand_r accumulator registers and registered
// ALU operand drive. Operands are zero whenever the sequencer is not iterating.
module alu_mul_seq_dp
  import alu_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              iter_nxt,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b
);

  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mcand_nxt;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;

  // Accumulator update: the 17-bit ALU result shifts right into {hi, lo}.
  always_comb begin
    mcand_nxt = mcand_r;
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (load) begin
      mcand_nxt = mcand;
      hi_nxt    = '0;
      lo_nxt    = mplier;
    end else if (step) begin
      hi_nxt = {alu_cout, alu_out[DATA_W-1:1]};
      lo_nxt = {alu_out[0], lo[DATA_W-1:1]};
    end
  end

  // Operands are precomputed from next-state so the ALU sees flop outputs only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= '0;
      hi      <= '0;
      lo      <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      mcand_r <= mcand_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      alu_a   <= iter_nxt ? hi_nxt : '0;
      alu_b   <= iter_nxt ? addend_sel(lo_nxt[0], mcand_nxt) : '0;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// 16x16 unsigned multiply sequencer that borrows the shared ALU for one
// shift-and-add iteration per granted cycle; stalls while the grant is withheld.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] prod_hi,
  output logic [DATA_W-1:0] prod_lo,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              load;
  logic              step;
  logic              iter_nxt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  assign load     = (state == ST_IDLE) && start;
  assign step     = (state == ST_ITER) && alu_gnt;
  assign iter_nxt = (state_nxt == ST_ITER);

  // Next-state and iteration count; a denied cycle leaves everything untouched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ITER;
          cnt_nxt   = '0;
        end
      end
      ST_ITER: begin
        if (alu_gnt) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      alu_req <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy    <= iter_nxt;
      alu_req <= iter_nxt;
      done    <= (state_nxt == ST_DONE);
    end
  end

  alu_mul_seq_dp u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .iter_nxt (iter_nxt),
    .mcand    (mcand),
    .mplier   (mplier),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .hi       (hi),
    .lo       (lo),
    .alu_a    (alu_a),
    .alu_b    (alu_b)
  );

  assign prod_hi = hi;
  assign prod_lo = lo;
  assign alu_cin = 1'b0;
  assign alu_op  = ALU_OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and random checks of alu_mul_seq against a stub adder ALU and
// an independent grant-count latency model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_cout;

  always #5 clk = ~clk;

  // Shared ALU stand-in: plain 16-bit adder with carry out.
  assign {alu_cout, alu_out} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          mode;
    logic [31:0] prod;
    int          lat;
    int          reqs;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   starts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0: grant always, 1: denied on odd cycles after start, 2: random 3/4
  function automatic logic gnt_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Entered 1 time unit after a rising edge; that cycle is cycle 0 (start high).
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int mode,
                         input bit stray, output logic [31:0] prod, output int lat,
                         output int reqs, output int lat_model);
    int          cyc;
    int          grants;
    bit          model_iter;
    bit          denied_prev;
    logic [15:0] pa;
    logic [15:0] pb;
    start = 1'b1;
    mcand = a;
    mplier = b;
    starts++;
    cyc = 0;
    grants = 0;
    lat = -1;
    lat_model = -1;
    reqs = 0;
    denied_prev = 1'b0;
    pa = '0;
    pb = '0;
    while (lat < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      mcand  = 16'($urandom);
      mplier = 16'($urandom);
      model_iter = (grants < 16);
      if (grants == 16 && lat_model < 0) lat_model = cyc;
      chk("busy", 32'(busy), 32'(model_iter));
      chk("alu_req", 32'(alu_req), 32'(model_iter));
      if (!model_iter) begin
        chk("alu_a_idle", 32'(alu_a), 32'h0);
        chk("alu_b_idle", 32'(alu_b), 32'h0);
      end
      if (model_iter && denied_prev) begin
        chk("alu_a_hold", 32'(alu_a), 32'(pa));
        chk("alu_b_hold", 32'(alu_b), 32'(pb));
      end
      if (alu_req) reqs++;
      if (done) begin
        lat = cyc;
        dones++;
      end
      alu_gnt = gnt_for(mode, cyc);
      denied_prev = model_iter && !alu_gnt;
      pa = alu_a;
      pb = alu_b;
      if (model_iter && alu_gnt) grants++;
      start = stray && (cyc == 5 || done);
    end
    if (lat < 0) chk("done_timeout", 32'h0, 32'h1);
    prod = {prod_hi, prod_lo};
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("prod_hold", {prod_hi, prod_lo}, prod);
    if (stray) begin
      repeat (5) begin
        @(posedge clk); #1;
        if (done) dones++;
        chk("stray_done", 32'(done), 32'h0);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_prod", {prod_hi, prod_lo}, prod);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_req"}, 32'(alu_req), 32'h0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'h0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'h0);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, 32'h0);
    chk({tag, "_cin"}, 32'(alu_cin), 32'h0);
    chk({tag, "_op"}, 32'(alu_op), 32'h0);
  endtask

  initial begin
    logic [31:0] prod;
    logic [31:0] exp;
    int          lat;
    int          reqs;
    int          lat_model;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'h0003, 16'h0005, 0, 32'h0000_000F, 17, 16};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001, 17, 16};
    vecs[2] = '{16'h0000, 16'hABCD, 0, 32'h0000_0000, 17, 16};
    vecs[3] = '{16'h8000, 16'h0002, 0, 32'h0001_0000, 17, 16};
    vecs[4] = '{16'h1234, 16'h5678, 1, 32'h0626_0060, 33, 32};
    vecs[5] = '{16'hFFFF, 16'h0001, 0, 32'h0000_FFFF, 17, 16};
    vecs[6] = '{16'h0001, 16'hFFFF, 1, 32'h0000_FFFF, 33, 32};

    rst_n   = 1'b0;
    start   = 1'b0;
    mcand   = '0;
    mplier  = '0;
    alu_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].mode, 1'b0, prod, lat, reqs, lat_model);
      chk($sformatf("vec%0d_prod", i), prod, vecs[i].prod);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_reqs", i), 32'(reqs), 32'(vecs[i].reqs));
      chk($sformatf("vec%0d_model_lat", i), 32'(lat), 32'(lat_model));
    end

    // start pulses during ITER and DONE must be dropped
    run_mul(16'h00FF, 16'h0101, 0, 1'b1, prod, lat, reqs, lat_model);
    chk("stray_prod_val", prod, 32'h0000_FFFF);
    chk("stray_lat", 32'(lat), 32'd17);

    // reset in cycle 8 abandons the multiply
    start   = 1'b1;
    mcand   = 16'hABCD;
    mplier  = 16'h1234;
    alu_gnt = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'h0);
      chk("midrst_no_busy", 32'(busy), 32'h0);
    end
    rst_n = 1'b1;
    run_mul(16'd7, 16'd9, 0, 1'b0, prod, lat, reqs, lat_model);
    chk("post_rst_prod", prod, 32'd63);
    chk("post_rst_lat", 32'(lat), 32'd17);

    for (int n = 0; n < 1500; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n == 0) begin
        ra = 16'hFFFF;
        rb = 16'hFFFF;
      end
      exp = 32'(ra) * 32'(rb);
      run_mul(ra, rb, 2, 1'b0, prod, lat, reqs, lat_model);
      chk($sformatf("rand%0d_prod", n), prod, exp);
      chk($sformatf("rand%0d_lat", n), 32'(lat), 32'(lat_model));
    end

    chk("done_count", 32'(dones), 32'(starts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
